// File: rtl/pe_wrapper.sv
// Single-tile int8 HWC convolution PE with weight, activation and 32-bit output buffers.
// Optional build macro PE_RELU_EN clamps negative channel results to zero before write-back.
module pe_wrapper #(
  parameter int COUT   = 4,
  parameter int LANES  = 16,
  parameter int WDEPTH = 1024,
  parameter int ADEPTH = 1024,
  parameter int ODEPTH = 1024
) (
  input  logic         clk_0,
  input  logic         rst_n_0,
  input  logic         cfg_we_0,
  input  logic [3:0]   cfg_addr_0,
  input  logic [31:0]  cfg_wdata_0,
  output logic [31:0]  cfg_rdata_0,
  input  logic [15:0]  addra_0,
  input  logic [127:0] dina_0,
  input  logic         wea_0,
  input  logic [15:0]  addra_1,
  input  logic [127:0] dina_1,
  input  logic         wea_1,
  input  logic [9:0]   addr1_0,
  input  logic         en1_0,
  output logic [511:0] doutb_0
);
  localparam int WAW = $clog2(WDEPTH);
  localparam int AAW = $clog2(ADEPTH);
  localparam int OAW = $clog2(ODEPTH);
  localparam int CW  = (COUT > 1) ? $clog2(COUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FETCH, S_MAC, S_WRITE, S_DONE} state_t;
  state_t state_reg;

  logic [3:0] kh_reg, kw_reg, pad_reg, stride_reg;
  logic [7:0] in_h_reg, in_w_reg, out_h_reg, out_w_reg;
  logic [3:0] kh_run, kw_run, pad_run, stride_run;
  logic [7:0] in_h_run, in_w_run, out_h_run, out_w_run;
  logic       done_reg, busy_reg;
  logic [7:0] oy_reg, ox_reg;
  logic [3:0] ky_reg, kx_reg;
  logic [CW-1:0] c_reg;
  logic [31:0] acc_reg [COUT];

  logic [127:0] wbuf [WDEPTH];
  logic [127:0] abuf [ADEPTH];
  logic [511:0] obuf [ODEPTH];
  logic [127:0] w_rd_reg, act_rd_reg;
  logic [511:0] doutb_reg;

  logic unused_bits;
  assign unused_bits = &{1'b0, addra_0[15:WAW], addra_1[15:AAW], cfg_wdata_0[31:16]};

  logic start_pulse;
  assign start_pulse = cfg_we_0 && (cfg_addr_0 == 4'd0) && cfg_wdata_0[0];

  // Input coordinates in unsigned 16-bit: a negative result shows up as bit 15 set.
  logic [15:0] iy_calc, ix_calc, w_base;
  logic        pos_valid, c_last, act_re, w_re;
  logic [AAW-1:0] act_raddr;
  logic [WAW-1:0] w_raddr;
  logic [OAW-1:0] o_waddr;
  assign iy_calc   = 16'(oy_reg) * 16'(stride_run) + 16'(ky_reg) - 16'(pad_run);
  assign ix_calc   = 16'(ox_reg) * 16'(stride_run) + 16'(kx_reg) - 16'(pad_run);
  assign pos_valid = !iy_calc[15] && (iy_calc < 16'(in_h_run)) &&
                     !ix_calc[15] && (ix_calc < 16'(in_w_run));
  assign act_raddr = AAW'(iy_calc * 16'(in_w_run) + ix_calc);
  assign w_base    = (16'(ky_reg) * 16'(kw_run) + 16'(kx_reg)) * 16'(COUT);
  assign c_last    = (c_reg == CW'(COUT - 1));
  // FETCH loads the weight for c=0; each MAC cycle prefetches the next channel's weight.
  assign w_raddr   = WAW'(w_base + ((state_reg == S_MAC) ? (16'(c_reg) + 16'd1) : 16'd0));
  assign act_re    = (state_reg == S_FETCH) && pos_valid;
  assign w_re      = pos_valid && ((state_reg == S_FETCH) || ((state_reg == S_MAC) && !c_last));
  assign o_waddr   = OAW'(16'(oy_reg) * 16'(out_w_run) + 16'(ox_reg));

  logic signed [15:0] prod [LANES];
  logic [31:0] dot_sum;
  logic [511:0] out_word;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_prod
      assign prod[gi] = $signed(act_rd_reg[8*gi +: 8]) * $signed(w_rd_reg[8*gi +: 8]);
    end
    for (genvar gi = 0; gi < LANES; gi++) begin : g_out
      if (gi < COUT) begin : g_act
`ifdef PE_RELU_EN
        assign out_word[32*gi +: 32] = acc_reg[gi][31] ? 32'd0 : acc_reg[gi];
`else
        assign out_word[32*gi +: 32] = acc_reg[gi];
`endif
      end else begin : g_zero
        assign out_word[32*gi +: 32] = 32'd0;
      end
    end
  endgenerate

  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < LANES; i++) dot_sum = dot_sum + 32'(prod[i]);
  end

  always_ff @(posedge clk_0) begin
    if (wea_0) wbuf[addra_0[WAW-1:0]] <= dina_0;
    if (w_re)  w_rd_reg <= wbuf[w_raddr];
  end

  always_ff @(posedge clk_0) begin
    if (wea_1)  abuf[addra_1[AAW-1:0]] <= dina_1;
    if (act_re) act_rd_reg <= abuf[act_raddr];
  end

  always_ff @(posedge clk_0) begin
    if (state_reg == S_WRITE) obuf[o_waddr] <= out_word;
    if (!rst_n_0)   doutb_reg <= '0;
    else if (en1_0) doutb_reg <= obuf[addr1_0[OAW-1:0]];
  end
  assign doutb_0 = doutb_reg;

  always_comb begin
    cfg_rdata_0 = '0;
    case (cfg_addr_0)
      4'd1: cfg_rdata_0 = {30'd0, busy_reg, done_reg};
      4'd2: cfg_rdata_0 = {20'd0, kh_reg, 4'd0, kw_reg};
      4'd3: cfg_rdata_0 = {16'd0, in_h_reg, in_w_reg};
      4'd4: cfg_rdata_0 = {24'd0, pad_reg, stride_reg};
      4'd5: cfg_rdata_0 = {16'd0, out_h_reg, out_w_reg};
      default: cfg_rdata_0 = '0;
    endcase
  end

  always_ff @(posedge clk_0) begin
    if (!rst_n_0) begin
      state_reg <= S_IDLE;
      done_reg <= 1'b0;  busy_reg <= 1'b0;
      kh_reg <= 4'd1;    kw_reg <= 4'd1;    pad_reg <= 4'd0;  stride_reg <= 4'd1;
      in_h_reg <= '0;    in_w_reg <= '0;    out_h_reg <= '0;  out_w_reg <= '0;
      kh_run <= 4'd1;    kw_run <= 4'd1;    pad_run <= 4'd0;  stride_run <= 4'd1;
      in_h_run <= '0;    in_w_run <= '0;    out_h_run <= '0;  out_w_run <= '0;
      oy_reg <= '0; ox_reg <= '0; ky_reg <= '0; kx_reg <= '0; c_reg <= '0;
    end else begin
      if (cfg_we_0) begin
        case (cfg_addr_0)
          4'd2: begin kh_reg <= cfg_wdata_0[11:8]; kw_reg <= cfg_wdata_0[3:0]; end
          4'd3: begin in_h_reg <= cfg_wdata_0[15:8]; in_w_reg <= cfg_wdata_0[7:0]; end
          4'd4: begin pad_reg <= cfg_wdata_0[7:4]; stride_reg <= cfg_wdata_0[3:0]; end
          4'd5: begin out_h_reg <= cfg_wdata_0[15:8]; out_w_reg <= cfg_wdata_0[7:0]; end
          default: ;
        endcase
      end
      case (state_reg)
        S_IDLE: if (start_pulse) begin
          done_reg <= 1'b0;  busy_reg <= 1'b1;
          kh_run <= kh_reg;  kw_run <= kw_reg;  pad_run <= pad_reg;
          stride_run <= (stride_reg == 4'd0) ? 4'd1 : stride_reg;
          in_h_run <= in_h_reg;    in_w_run <= in_w_reg;
          out_h_run <= out_h_reg;  out_w_run <= out_w_reg;
          oy_reg <= '0;  ox_reg <= '0;
          state_reg <= (out_h_reg == 8'd0 || out_w_reg == 8'd0) ? S_DONE : S_CLR;
        end
        S_CLR: begin
          for (int i = 0; i < COUT; i++) acc_reg[i] <= '0;
          ky_reg <= '0;  kx_reg <= '0;  c_reg <= '0;
          state_reg <= (kh_run == 4'd0 || kw_run == 4'd0) ? S_WRITE : S_FETCH;
        end
        S_FETCH: begin
          c_reg <= '0;
          state_reg <= S_MAC;
        end
        S_MAC: begin
          if (pos_valid) acc_reg[c_reg] <= acc_reg[c_reg] + dot_sum;
          if (!c_last) begin
            c_reg <= c_reg + CW'(1);
          end else begin
            c_reg <= '0;
            state_reg <= S_FETCH;
            if (kx_reg == kw_run - 4'd1) begin
              kx_reg <= '0;
              if (ky_reg == kh_run - 4'd1) state_reg <= S_WRITE;
              else ky_reg <= ky_reg + 4'd1;
            end else begin
              kx_reg <= kx_reg + 4'd1;
            end
          end
        end
        S_WRITE: begin
          state_reg <= S_CLR;
          if (ox_reg == out_w_run - 8'd1) begin
            ox_reg <= '0;
            if (oy_reg == out_h_run - 8'd1) state_reg <= S_DONE;
            else oy_reg <= oy_reg + 8'd1;
          end else begin
            ox_reg <= ox_reg + 8'd1;
          end
        end
        S_DONE: begin
          busy_reg <= 1'b0;  done_reg <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_wrapper.sv
// Scoreboard bench for pe_wrapper: directed convolution runs, output reads checked by a monitor.
module tb_pe_wrapper;
  logic         clk_0 = 1'b0;
  logic         rst_n_0;
  logic         cfg_we_0;
  logic [3:0]   cfg_addr_0;
  logic [31:0]  cfg_wdata_0;
  logic [31:0]  cfg_rdata_0;
  logic [15:0]  addra_0, addra_1;
  logic [127:0] dina_0, dina_1;
  logic         wea_0, wea_1;
  logic [9:0]   addr1_0;
  logic         en1_0;
  logic [511:0] doutb_0;

  always #5 clk_0 = ~clk_0;

  pe_wrapper dut (
    .clk_0(clk_0), .rst_n_0(rst_n_0),
    .cfg_we_0(cfg_we_0), .cfg_addr_0(cfg_addr_0), .cfg_wdata_0(cfg_wdata_0), .cfg_rdata_0(cfg_rdata_0),
    .addra_0(addra_0), .dina_0(dina_0), .wea_0(wea_0),
    .addra_1(addra_1), .dina_1(dina_1), .wea_1(wea_1),
    .addr1_0(addr1_0), .en1_0(en1_0), .doutb_0(doutb_0)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [511:0] exp_q [$];
  int           addr_q [$];
  logic [511:0] mon_exp;
  int           mon_addr;
  logic         rd_vld = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // Read data appears one cycle after the enable; the monitor pops the matching expectation.
  always @(posedge clk_0) rd_vld <= en1_0;
  always @(negedge clk_0) begin
    if (rd_vld) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL out_read: unexpected read data %h", doutb_0[127:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_addr = addr_q.pop_front();
        if (doutb_0 !== mon_exp) begin
          tests_failed++;
          $display("FAIL out_read addr=%0d: got %h expected %h", mon_addr, doutb_0[127:0], mon_exp[127:0]);
          if (doutb_0[511:128] !== mon_exp[511:128])
            $display("FAIL out_read_hi addr=%0d: got %h expected 0", mon_addr, doutb_0[511:128]);
        end else begin
          $display("[TB] ok out_read addr=%0d ch0=%0d", mon_addr, $signed(doutb_0[31:0]));
        end
      end
    end
  end

  function automatic logic [511:0] mkw(input int v);
    logic [511:0] w = '0;
    for (int c = 0; c < 4; c++) w[32*c +: 32] = v;
    return w;
  endfunction

  function automatic logic [127:0] lanes4(input logic [7:0] v);
    logic [127:0] w = '0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = v;
    return w;
  endfunction

  function automatic int valid_cnt(input int o);
    return (o == 0 || o == 3) ? 2 : 3;
  endfunction

  task automatic tick();
    @(posedge clk_0); #1;
  endtask

  task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
    cfg_we_0 = 1'b1; cfg_addr_0 = a; cfg_wdata_0 = d;
    tick();
    cfg_we_0 = 1'b0;
  endtask

  task automatic cfg_chk(input logic [3:0] a, input logic [31:0] exp, input string name);
    cfg_addr_0 = a; #1;
    check32(name, cfg_rdata_0, exp);
  endtask

  task automatic wr_w(input int a, input logic [127:0] d);
    wea_0 = 1'b1; addra_0 = 16'(a); dina_0 = d;
    tick();
    wea_0 = 1'b0;
  endtask

  task automatic wr_a(input int a, input logic [127:0] d);
    wea_1 = 1'b1; addra_1 = 16'(a); dina_1 = d;
    tick();
    wea_1 = 1'b0;
  endtask

  task automatic rd_out(input int a, input logic [511:0] exp);
    exp_q.push_back(exp);
    addr_q.push_back(a);
    en1_0 = 1'b1; addr1_0 = 10'(a);
    tick();
    en1_0 = 1'b0;
  endtask

  task automatic cfg_geom(input int kh, input int kw, input int ih, input int iw,
                          input int pad, input int stride, input int oh, input int ow);
    cfg_wr(4'd2, 32'((kh << 8) | kw));
    cfg_wr(4'd3, 32'((ih << 8) | iw));
    cfg_wr(4'd4, 32'((pad << 4) | stride));
    cfg_wr(4'd5, 32'((oh << 8) | ow));
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int n = 0;
    cfg_addr_0 = 4'd1; #1;
    while (!cfg_rdata_0[0] && n < max_cycles) begin
      tick();
      n++;
    end
    check32(name, {31'd0, cfg_rdata_0[0]}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_0 = 1'b0; cfg_we_0 = 1'b0; cfg_addr_0 = '0; cfg_wdata_0 = '0;
    addra_0 = '0; addra_1 = '0; dina_0 = '0; dina_1 = '0; wea_0 = 1'b0; wea_1 = 1'b0;
    addr1_0 = '0; en1_0 = 1'b0;
    repeat (3) tick();
    cfg_chk(4'd2, 32'h101, "reset_kdim");
    cfg_chk(4'd3, 32'h0,   "reset_idim");
    cfg_chk(4'd4, 32'h1,   "reset_conv");
    cfg_chk(4'd5, 32'h0,   "reset_odim");
    cfg_chk(4'd1, 32'h0,   "reset_status");
    check32("reset_doutb_zero", {31'd0, |doutb_0}, 32'd0);
    rst_n_0 = 1'b1;
    tick();
    cfg_wr(4'd4, 32'hFFFF_FFFF);
    cfg_chk(4'd4, 32'hFF, "conv_field_mask");
    cfg_chk(4'd0, 32'h0,  "ctrl_reads_zero");
    cfg_chk(4'd7, 32'h0,  "unmapped_reads_zero");

    // Negative weight, 1x1 kernel
    for (int i = 0; i < 4; i++)  wr_w(i, 128'hFF);
    for (int i = 0; i < 16; i++) wr_a(i, 128'h7F);
    cfg_geom(1, 1, 4, 4, 0, 1, 4, 4);
    cfg_wr(4'd0, 32'd1);
    wait_done("neg_done", 3000);
`ifdef PE_RELU_EN
    rd_out(0, mkw(0)); rd_out(5, mkw(0)); rd_out(15, mkw(0));
`else
    rd_out(0, mkw(-127)); rd_out(5, mkw(-127)); rd_out(15, mkw(-127));
`endif

    // Stride 2, activation = iy*4+ix
    for (int i = 0; i < 16; i++) wr_w(i, 128'h1);
    for (int i = 0; i < 16; i++) wr_a(i, 128'(i));
    cfg_geom(2, 2, 4, 4, 0, 2, 2, 2);
    cfg_wr(4'd0, 32'd1);
    wait_done("stride_done", 3000);
    rd_out(0, mkw(10)); rd_out(1, mkw(18)); rd_out(2, mkw(42)); rd_out(3, mkw(50));

    // All ones, 2x2 kernel
    for (int i = 0; i < 36; i++) wr_w(i, lanes4(8'd1));
    for (int i = 0; i < 16; i++) wr_a(i, lanes4(8'd1));
    cfg_geom(2, 2, 4, 4, 0, 1, 3, 3);
    cfg_wr(4'd0, 32'd1);
    cfg_chk(4'd1, 32'd2, "status_busy");
    wait_done("ones_done", 3000);
    cfg_chk(4'd1, 32'd1, "status_done");
    for (int i = 0; i < 9; i++) rd_out(i, mkw(16));

    // 3x3 kernel with pad 1
    cfg_geom(3, 3, 4, 4, 1, 1, 4, 4);
    cfg_wr(4'd0, 32'd1);
    wait_done("pad_done", 3000);
    for (int oy = 0; oy < 4; oy++)
      for (int ox = 0; ox < 4; ox++)
        rd_out(oy*4 + ox, mkw(4 * valid_cnt(oy) * valid_cnt(ox)));

    // Geometry change and restart while busy must not affect the running job
    cfg_geom(2, 2, 4, 4, 0, 1, 3, 3);
    cfg_wr(4'd0, 32'd1);
    repeat (3) tick();
    cfg_wr(4'd5, 32'h0101);
    cfg_wr(4'd0, 32'd1);
    cfg_chk(4'd1, 32'd2, "status_busy_restart");
    wait_done("restart_done", 3000);
    cfg_chk(4'd5, 32'h0101, "odim_stored_while_busy");
    rd_out(4, mkw(16)); rd_out(8, mkw(16));

    // Reset mid-run, then a clean run
    cfg_geom(3, 3, 4, 4, 1, 1, 4, 4);
    cfg_wr(4'd0, 32'd1);
    repeat (20) tick();
    rst_n_0 = 1'b0;
    tick();
    rst_n_0 = 1'b1;
    cfg_chk(4'd1, 32'd0, "status_after_abort");
    cfg_geom(3, 3, 4, 4, 1, 1, 4, 4);
    cfg_wr(4'd0, 32'd1);
    wait_done("rerun_done", 3000);
    rd_out(5, mkw(36)); rd_out(9, mkw(36)); rd_out(15, mkw(16)); rd_out(1, mkw(24));

    // kw=0 writes zeros; out_h=0 finishes without writing
    cfg_geom(2, 0, 4, 4, 0, 1, 1, 1);
    cfg_wr(4'd0, 32'd1);
    wait_done("kw0_done", 3000);
    rd_out(0, mkw(0));
    cfg_geom(1, 1, 4, 4, 0, 1, 0, 4);
    cfg_wr(4'd0, 32'd1);
    wait_done("outh0_done", 10);
    rd_out(1, mkw(24));

    repeat (4) tick();
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
